// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a combinational instruction/data ROM.
// Fetch and load requesters share a single ROM port. Each access takes three cycles
// (IDLE -> ACCESS -> DONE). Ties are broken round-robin. The load path extracts bytes
// or halves in little-endian order and extends them, and it flags misaligned or
// illegal-size loads.
module rom_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [9:0]  fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_data,
  input  logic        load_req,
  input  logic [9:0]  load_addr,
  input  logic [1:0]  load_size,
  input  logic        load_signed,
  output logic        load_ready,
  output logic [31:0] load_data,
  output logic        load_error,
  output logic [9:0]  rom_address,
  input  logic [31:0] rom_data_in,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  // Grant encoding: 0 = fetch, 1 = load.
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [9:0]  addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] fetch_data_q, load_data_q;
  logic        load_error_q;
  logic        pick_load;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] shifted;
  logic [31:0] load_value;
  logic        load_bad;

  // Arbitration, request latching and state sequencing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    // On a tie, load wins only when fetch was not the loser last time.
    pick_load    = load_req && (!fetch_req || !last_grant_q);
    case (state_q)
      StIdle: begin
        if (fetch_req || load_req) begin
          grant_d      = pick_load;
          last_grant_d = pick_load;
          addr_d       = pick_load ? load_addr : fetch_addr;
          if (pick_load) begin
            size_d   = load_size;
            signed_d = load_signed;
          end
          state_d = StAccess;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
    end
  end

  // Little-endian lane extraction, extension and alignment check for loads.
  always_comb begin
    shifted    = rom_data_in >> {addr_q[1:0], 3'b000};
    byte_sel   = shifted[7:0];
    half_sel   = addr_q[1] ? rom_data_in[31:16] : rom_data_in[15:0];
    load_value = '0;
    load_bad   = 1'b0;
    case (size_q)
      2'd0: load_value = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      2'd1: begin
        load_bad   = addr_q[0];
        load_value = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      end
      2'd2: begin
        load_bad   = (addr_q[1:0] != 2'b00);
        load_value = rom_data_in;
      end
      default: load_bad = 1'b1;
    endcase
  end

  // Capture ROM data into the granted port at the ACCESS->DONE edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_data_q <= '0;
      load_data_q  <= '0;
      load_error_q <= 1'b0;
    end else if (state_q == StAccess) begin
      if (grant_q) begin
        load_data_q  <= load_bad ? 32'b0 : load_value;
        load_error_q <= load_bad;
      end else begin
        fetch_data_q <= rom_data_in;
      end
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy        = (state_q != StIdle);
    rom_address = (state_q == StAccess) ? {addr_q[9:2], 2'b00} : 10'b0;
    fetch_ready = (state_q == StDone) && !grant_q;
    load_ready  = (state_q == StDone) && grant_q;
    load_error  = load_ready && load_error_q;
    fetch_data  = fetch_data_q;
    load_data   = load_data_q;
  end

endmodule
